// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter between instruction fetch and the LSU.
package mem_arb_pkg;

  localparam int unsigned StarveCntWidth = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LSU  = 2'd2
  } owner_e;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of consecutive cycles in which fetch was denied; at_limit forces a fetch grant.
module mem_arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int unsigned StarveLimit = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [StarveCntWidth-1:0] Limit = StarveCntWidth'(StarveLimit);

  logic [StarveCntWidth-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != Limit)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_limit = (cnt == Limit);

endmodule : mem_arb_starve_cnt

// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter: LSU has fixed priority, a starvation counter guarantees fetch progress,
// and read data is returned one cycle after the grant with a per-port valid strobe.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned Address     = 8,
  parameter int unsigned StarveLimit = 4
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 if_req,
  input  logic [Address-1:0]   if_addr,
  output logic                 if_gnt,
  output logic                 if_rvalid,
  output logic [DataWidth-1:0] if_rdata,

  input  logic                 lsu_req,
  input  logic                 lsu_we,
  input  logic [3:0]           lsu_wmask,
  input  logic [Address-1:0]   lsu_addr,
  input  logic [DataWidth-1:0] lsu_wdata,
  output logic                 lsu_gnt,
  output logic                 lsu_rvalid,
  output logic [DataWidth-1:0] lsu_rdata,

  output logic                 mem_en,
  output logic                 mem_we,
  output logic [3:0]           mem_wmask,
  output logic [Address-1:0]   mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  input  logic [DataWidth-1:0] mem_rdata
);

  logic   at_limit;
  logic   force_if;
  owner_e owner;
  owner_e owner_next;

  mem_arb_starve_cnt #(
    .StarveLimit (StarveLimit)
  ) u_starve_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (if_req & ~if_gnt),
    .clr      (if_gnt | ~if_req),
    .at_limit (at_limit)
  );

  assign force_if = at_limit & if_req;
  assign lsu_gnt  = lsu_req & ~force_if;
  assign if_gnt   = if_req & (~lsu_req | force_if);

  // NOTE: every variable gets a default first so no path through the block infers a latch.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_wmask = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (lsu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = lsu_we;
      mem_wmask = lsu_we ? lsu_wmask : 4'b0000;
      mem_addr  = lsu_addr;
      mem_wdata = lsu_we ? lsu_wdata : '0;
    end else if (if_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = if_addr;
    end
  end

  // Stores produce no response, so only a load grant claims the return slot for the LSU.
  always_comb begin
    owner_next = OWN_NONE;
    if (if_gnt) begin
      owner_next = OWN_IF;
    end else if (lsu_gnt && !lsu_we) begin
      owner_next = OWN_LSU;
    end
  end

  // NOTE: owner is reset so an in-flight response is dropped; the data path needs no reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner <= OWN_NONE;
    end else begin
      owner <= owner_next;
    end
  end

  assign if_rvalid  = (owner == OWN_IF);
  assign lsu_rvalid = (owner == OWN_LSU);
  assign if_rdata   = mem_rdata;
  assign lsu_rdata  = mem_rdata;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a byte-masked SRAM model behind it.
module tb_mem_port_arbiter;

  localparam int unsigned DataWidth   = 32;
  localparam int unsigned Address     = 8;
  localparam int unsigned StarveLimit = 4;

  logic                 clk;
  logic                 rst;
  logic                 if_req;
  logic [Address-1:0]   if_addr;
  logic                 if_gnt;
  logic                 if_rvalid;
  logic [DataWidth-1:0] if_rdata;
  logic                 lsu_req;
  logic                 lsu_we;
  logic [3:0]           lsu_wmask;
  logic [Address-1:0]   lsu_addr;
  logic [DataWidth-1:0] lsu_wdata;
  logic                 lsu_gnt;
  logic                 lsu_rvalid;
  logic [DataWidth-1:0] lsu_rdata;
  logic                 mem_en;
  logic                 mem_we;
  logic [3:0]           mem_wmask;
  logic [Address-1:0]   mem_addr;
  logic [DataWidth-1:0] mem_wdata;
  logic [DataWidth-1:0] mem_rdata;

  logic [DataWidth-1:0] mem_model [256];

  int checks;
  int errors;

  mem_port_arbiter #(
    .DataWidth   (DataWidth),
    .Address     (Address),
    .StarveLimit (StarveLimit)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .lsu_req    (lsu_req),
    .lsu_we     (lsu_we),
    .lsu_wmask  (lsu_wmask),
    .lsu_addr   (lsu_addr),
    .lsu_wdata  (lsu_wdata),
    .lsu_gnt    (lsu_gnt),
    .lsu_rvalid (lsu_rvalid),
    .lsu_rdata  (lsu_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_wmask  (mem_wmask),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: byte-masked writes, registered read data one cycle after a read enable.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_wmask[b]) mem_model[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end else begin
        mem_rdata <= mem_model[mem_addr];
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    if_req    = 1'b0;
    if_addr   = '0;
    lsu_req   = 1'b0;
    lsu_we    = 1'b0;
    lsu_wmask = 4'b0000;
    lsu_addr  = '0;
    lsu_wdata = '0;
  endtask

  task automatic drive_lsu_load(input logic [Address-1:0] addr);
    lsu_req   = 1'b1;
    lsu_we    = 1'b0;
    lsu_wmask = 4'b0000;
    lsu_addr  = addr;
    lsu_wdata = '0;
  endtask

  task automatic test_reset();
    drive_idle();
    #2;
    checks++;
    if ({if_rvalid, lsu_rvalid, mem_en} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: rvalids/mem_en=%b expected 000", {if_rvalid, lsu_rvalid, mem_en});
    end
    if_req  = 1'b1;
    if_addr = 8'h10;
    drive_lsu_load(8'h20);
    #1;
    checks++;
    if ({if_gnt, lsu_gnt, mem_en, mem_addr} !== {3'b011, 8'h20}) begin
      errors++;
      $display("FAIL reset_comb_grant: gnt/en/addr=%b/%b/%b/%h expected 0/1/1/20",
               if_gnt, lsu_gnt, mem_en, mem_addr);
    end
    drive_idle();
    @(posedge clk);
    #1;
    checks++;
    if ({if_rvalid, lsu_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_hold_rvalid: %b expected 00", {if_rvalid, lsu_rvalid});
    end
    rst = 1'b1;
  endtask

  task automatic test_if_only();
    if_req  = 1'b1;
    if_addr = 8'h10;
    @(negedge clk);
    checks++;
    if ({if_gnt, lsu_gnt, mem_en, mem_we, mem_wmask, mem_addr} !== {4'b1010, 4'b0000, 8'h10}) begin
      errors++;
      $display("FAIL if_only_grant: ifg=%b lg=%b en=%b we=%b wm=%b addr=%h expected 1 0 1 0 0000 10",
               if_gnt, lsu_gnt, mem_en, mem_we, mem_wmask, mem_addr);
    end
    next_cycle();
    drive_idle();
    checks++;
    if ({if_rvalid, lsu_rvalid, if_rdata} !== {2'b10, 32'h0050_0093}) begin
      errors++;
      $display("FAIL if_only_resp: rv=%b%b data=%h expected 10 00500093",
               if_rvalid, lsu_rvalid, if_rdata);
    end
    next_cycle();
    checks++;
    if ({if_rvalid, lsu_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL if_only_done: rvalids=%b expected 00", {if_rvalid, lsu_rvalid});
    end
  endtask

  task automatic test_store_load();
    lsu_req   = 1'b1;
    lsu_we    = 1'b1;
    lsu_wmask = 4'b0011;
    lsu_addr  = 8'h20;
    lsu_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if ({lsu_gnt, mem_en, mem_we, mem_wmask, mem_addr, mem_wdata} !==
        {3'b111, 4'b0011, 8'h20, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL store_grant: g=%b en=%b we=%b wm=%b addr=%h wd=%h expected 1 1 1 0011 20 deadbeef",
               lsu_gnt, mem_en, mem_we, mem_wmask, mem_addr, mem_wdata);
    end
    next_cycle();
    drive_lsu_load(8'h20);
    checks++;
    if ({if_rvalid, lsu_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL store_no_resp: rvalids=%b expected 00", {if_rvalid, lsu_rvalid});
    end
    @(negedge clk);
    checks++;
    if ({lsu_gnt, mem_en, mem_we, mem_wmask} !== {3'b110, 4'b0000}) begin
      errors++;
      $display("FAIL load_grant: g=%b en=%b we=%b wm=%b expected 1 1 0 0000",
               lsu_gnt, mem_en, mem_we, mem_wmask);
    end
    next_cycle();
    drive_idle();
    checks++;
    if ({if_rvalid, lsu_rvalid, lsu_rdata} !== {2'b01, 32'h0000_BEEF}) begin
      errors++;
      $display("FAIL load_resp: rv=%b%b data=%h expected 01 0000beef", if_rvalid, lsu_rvalid, lsu_rdata);
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    logic       exp_if;
    logic [1:0] exp_rv;
    if_req  = 1'b1;
    if_addr = 8'h10;
    drive_lsu_load(8'h20);
    for (int c = 0; c < 10; c++) begin
      exp_if = ((c % 5) == 4);
      @(negedge clk);
      checks++;
      if ({if_gnt, lsu_gnt, mem_addr} !== {exp_if, ~exp_if, (exp_if ? 8'h10 : 8'h20)}) begin
        errors++;
        $display("FAIL starve_grant[%0d]: ifg=%b lg=%b addr=%h expected ifg=%b", c,
                 if_gnt, lsu_gnt, mem_addr, exp_if);
      end
      next_cycle();
      exp_rv = exp_if ? 2'b10 : 2'b01;
      checks++;
      if ({if_rvalid, lsu_rvalid} !== exp_rv) begin
        errors++;
        $display("FAIL starve_resp[%0d]: rvalids=%b expected %b", c, {if_rvalid, lsu_rvalid}, exp_rv);
      end
    end
    drive_idle();
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [1:0]           kinds [3];
    logic [DataWidth-1:0] exp_data;
    kinds[0] = 2'b10;
    kinds[1] = 2'b01;
    kinds[2] = 2'b10;
    for (int i = 0; i < 3; i++) begin
      drive_idle();
      if (kinds[i][1]) begin
        if_req  = 1'b1;
        if_addr = 8'h10;
      end else begin
        drive_lsu_load(8'h20);
      end
      @(negedge clk);
      checks++;
      if ({if_gnt, lsu_gnt} !== kinds[i]) begin
        errors++;
        $display("FAIL b2b_grant[%0d]: gnt=%b expected %b", i, {if_gnt, lsu_gnt}, kinds[i]);
      end
      next_cycle();
      exp_data = kinds[i][1] ? 32'h0050_0093 : 32'h0000_BEEF;
      checks++;
      if ({if_rvalid, lsu_rvalid, mem_rdata} !== {kinds[i], exp_data}) begin
        errors++;
        $display("FAIL b2b_resp[%0d]: rv=%b%b data=%h expected %b %h", i, if_rvalid, lsu_rvalid,
                 mem_rdata, kinds[i], exp_data);
      end
    end
    drive_idle();
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    if_req  = 1'b1;
    if_addr = 8'h10;
    next_cycle();
    checks++;
    if (if_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: if_rvalid=%b expected 1", if_rvalid);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({if_rvalid, lsu_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_async: rvalids=%b expected 00", {if_rvalid, lsu_rvalid});
    end
    next_cycle();
    checks++;
    if (if_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_held: if_rvalid=%b expected 0", if_rvalid);
    end
    drive_idle();
    rst = 1'b1;
    next_cycle();
    checks++;
    if ({if_rvalid, lsu_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_release: rvalids=%b expected 00", {if_rvalid, lsu_rvalid});
    end
    // Build up the starve count, reset, then the full limit must elapse before fetch wins.
    if_req  = 1'b1;
    if_addr = 8'h10;
    drive_lsu_load(8'h20);
    next_cycle();
    next_cycle();
    #3;
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({if_gnt, lsu_gnt} !== ((c == 4) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL midrst_cnt[%0d]: gnt=%b expected %b", c, {if_gnt, lsu_gnt},
                 ((c == 4) ? 2'b10 : 2'b01));
      end
      next_cycle();
    end
    drive_idle();
    next_cycle();
  endtask

  task automatic test_idle();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({if_gnt, lsu_gnt, mem_en, mem_we, mem_wmask, mem_addr, mem_wdata} !== '0) begin
        errors++;
        $display("FAIL idle_mem[%0d]: gnt=%b%b en=%b we=%b wm=%b addr=%h wd=%h expected all 0", c,
                 if_gnt, lsu_gnt, mem_en, mem_we, mem_wmask, mem_addr, mem_wdata);
      end
      next_cycle();
      checks++;
      if ({if_rvalid, lsu_rvalid} !== 2'b00) begin
        errors++;
        $display("FAIL idle_rvalid[%0d]: rvalids=%b expected 00", c, {if_rvalid, lsu_rvalid});
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem_model[i] = '0;
    mem_model[8'h10] = 32'h0050_0093;
    mem_rdata = '0;
    rst = 1'b0;
    drive_idle();

    test_reset();
    test_if_only();
    test_store_load();
    test_starvation();
    test_back_to_back();
    test_reset_mid_read();
    test_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mem_port_arbiter

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single-port word-addressed SRAM between the instruction-fetch stage and the load/store unit of the RV32I `microprocessor`. It issues at most one memory access per cycle and gives the LSU fixed priority. A starvation counter guarantees fetch progress. Read data is routed back one cycle later with a per-port valid strobe. It sits between the core's IF/LSU ports and the memory macro, inside the core top.

## Interface
- `DataWidth`, 32, word width of memory and both requesters
- `Address`, 8, word-address width
- `StarveLimit`, 4, consecutive denied IF-request cycles before IF is forced to win; legal range 1..15
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch read request; held with `if_addr` stable until granted
- `if_addr`  in  Address  fetch word address
- `if_gnt`  out  1  fetch request accepted this cycle (combinational)
- `if_rvalid`  out  1  `if_rdata` valid (registered)
- `if_rdata`  out  DataWidth  fetch read data
- `lsu_req`  in  1  LSU request; held stable with all LSU inputs until granted
- `lsu_we`  in  1  1 = store, 0 = load
- `lsu_wmask`  in  4  byte enables for stores
- `lsu_addr`  in  Address  LSU word address
- `lsu_wdata`  in  DataWidth  store data
- `lsu_gnt`  out  1  LSU request accepted this cycle (combinational)
- `lsu_rvalid`  out  1  `lsu_rdata` valid; loads only (registered)
- `lsu_rdata`  out  DataWidth  load data
- `mem_en`  out  1  memory access this cycle
- `mem_we`  out  1  memory write
- `mem_wmask`  out  4  byte write enables; 0 on reads
- `mem_addr`  out  Address  memory word address
- `mem_wdata`  out  DataWidth  memory write data
- `mem_rdata`  in  DataWidth  read data, valid the cycle after a read `mem_en`

## Operation
- Each cycle, at most one grant is issued:
  - `lsu_gnt = lsu_req & !force_if`
  - `if_gnt = if_req & (!lsu_req | force_if)`
- `force_if` is asserted when `starve_cnt == StarveLimit` and `if_req` is high.
- Starve counter, width 4, saturating at `StarveLimit`:
  - increments when `if_req & !if_gnt`;
  - clears to 0 when `if_gnt` or `!if_req`.
- Memory outputs follow the granted port in the same cycle.
  - No grant: `mem_en = 0`; `mem_we`, `mem_wmask`, `mem_addr` and `mem_wdata` are 0.
  - IF grant: `mem_we = 0`, `mem_wmask = 0`.
- Response owner register (`OWN_NONE`/`OWN_IF`/`OWN_LSU`) is loaded every cycle:
  - `OWN_IF` on an IF grant;
  - `OWN_LSU` on an LSU load grant;
  - `OWN_NONE` otherwise, including on stores.
- `if_rvalid = (owner == OWN_IF)`; `lsu_rvalid = (owner == OWN_LSU)`.
- `if_rdata` and `lsu_rdata` both equal `mem_rdata`. They are qualified only by their rvalid.
- Stores produce no response.

## Timing
- Grant latency 0: `gnt` and `mem_en` in the same cycle as a qualifying `req`.
- Read latency 1: a grant in cycle N gives rvalid and data in cycle N+1.
- Back-to-back grants are allowed every cycle, to either port, with no bubble.
- Simultaneous requests: LSU wins unless `force_if`.
  - The losing port sees `gnt = 0` and must hold its request.
  - A request may not be withdrawn before grant; behaviour on withdrawal is not specified.
- Reset (`rst` low), asynchronous:
  - `owner = OWN_NONE`, `starve_cnt = 0`;
  - `if_rvalid` and `lsu_rvalid` go to 0 immediately.
  - Combinational outputs follow inputs, with `force_if = 0`.
- Reset mid-transaction: an in-flight read response is dropped and no rvalid is issued after reset release.
- The first grant can occur in the first rising edge after `rst` deasserts.

## Structure
- Package `mem_arb_pkg`: `owner_e` enum (`OWN_NONE`, `OWN_IF`, `OWN_LSU`) and the starve counter width constant (4).
- One sub-module, `mem_arb_starve_cnt`: saturating counter with inputs `inc`/`clr` and output `at_limit`, parameterised by `StarveLimit`.
- Grant logic, output muxing and the owner register stay in the top.

## Test plan
- IF only: `if_req = 1`, `if_addr = 0x10`, memory word 0x10 = 0x00500093.
  - Same cycle: `if_gnt = 1`, `mem_en = 1`, `mem_addr = 0x10`.
  - Next cycle: `if_rvalid = 1`, `if_rdata = 0x00500093`.
- LSU store then load, IF idle:
  - Store to 0x20 with `lsu_wmask = 4'b0011`, `lsu_wdata = 0xDEADBEEF`, old word 0x00000000. No `lsu_rvalid` follows.
  - Load from 0x20: `lsu_rvalid` next cycle with `lsu_rdata = 0x0000BEEF`.
- Both requesting continuously, `StarveLimit = 4`:
  - LSU is granted in cycles 0-3; IF is granted in cycle 4, with `lsu_gnt = 0` that cycle.
  - The counter returns to 0 and the pattern repeats.
- Alternating grants IF, LSU-load, IF on consecutive cycles: rvalids appear as `if_rvalid`, `lsu_rvalid`, `if_rvalid` in the next three cycles with no overlap.
- Reset mid-read:
  - IF granted in cycle N; `rst` pulled low before edge N+1.
  - `if_rvalid` stays 0 through reset and the cycle after release.
  - `starve_cnt` reads 0.
- Idle: no requests gives `mem_en = 0` and all mem outputs 0 for 10 cycles; both rvalids stay 0.
